// File: rtl/mp3dec_ctrl.sv
// mp3dec_ctrl: decoder reset/start/stop sequencer with FIFO level interrupts; read data 1 cycle after strobe, never stalls.
// Optional stall watchdog (auto soft reset) is built when MP3DEC_WDOG_EN is defined.
module mp3dec_ctrl #(
  parameter int CNT_W      = 10,
  parameter int RST_CYCLES = 16,
  parameter int WDOG_LIMIT = 4096
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             reg_sel,
  input  logic             reg_wr,
  input  logic [7:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  input  logic [CNT_W-1:0] ififo_cnt,
  input  logic [CNT_W-1:0] ofifo_cnt,
  input  logic             fifo_rst_busy,
  output logic             dec_rst,
  output logic             dec_en,
  output logic             intr
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
`ifdef MP3DEC_WDOG_EN
  localparam logic [3:0] INT_MASK = 4'hF;
`else
  localparam logic [3:0] INT_MASK = 4'h7;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RST  = 3'd1,
    S_WAIT = 3'd2,
    S_RUN  = 3'd3
  } state_t;

  state_t            state, state_nxt;
  logic [RC_W-1:0]   rst_cnt, rst_cnt_nxt;
  logic              rst_done_set;
  logic              wdog_fire;
  logic [1:0]        busy_ff;
  logic              busy_sync;
  logic [CNT_W-1:0]  in_thr, out_thr;
  logic [3:0]        int_en, int_stat, int_set, int_clr;
  logic              in_low, out_high, in_low_q, out_high_q;
  logic              run;
  logic              wr_stb, rd_stb;
  logic [5:0]        reg_idx;
  logic              ctrl_start, ctrl_stop, ctrl_srst;
  logic [31:0]       rd_mux;
  logic              unused_bits;

  assign wr_stb     = reg_sel & reg_wr;
  assign rd_stb     = reg_sel & ~reg_wr;
  assign reg_idx    = reg_addr[7:2];
  assign ctrl_start = wr_stb && (reg_idx == 6'h00) && reg_wdata[0];
  assign ctrl_stop  = wr_stb && (reg_idx == 6'h00) && reg_wdata[1];
  assign ctrl_srst  = wr_stb && (reg_idx == 6'h00) && reg_wdata[2];
  assign unused_bits = ^{reg_addr[1:0], reg_wdata};

  assign in_low    = (ififo_cnt <= in_thr);
  assign out_high  = (ofifo_cnt >= out_thr);
  assign run       = (state == S_RUN);
  assign busy_sync = busy_ff[1];

  // fifo_rst_busy is asynchronous to HCLK
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) busy_ff <= 2'b11;
    else          busy_ff <= {busy_ff[0], fifo_rst_busy};
  end

  always_comb begin
    state_nxt    = state;
    rst_cnt_nxt  = rst_cnt;
    rst_done_set = 1'b0;
    case (state)
      S_RST: begin
        if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
          state_nxt   = S_WAIT;
          rst_cnt_nxt = '0;
        end else begin
          rst_cnt_nxt = rst_cnt + 1'b1;
        end
      end
      S_WAIT: begin
        if (!busy_sync) begin
          state_nxt    = S_IDLE;
          rst_done_set = 1'b1;
        end
      end
      S_IDLE:  if (ctrl_start) state_nxt = S_RUN;
      S_RUN:   if (ctrl_stop)  state_nxt = S_IDLE;
      default: state_nxt = S_RST;
    endcase
    // Soft reset (software or watchdog) overrides everything and restarts the count
    if (ctrl_srst || wdog_fire) begin
      state_nxt    = S_RST;
      rst_cnt_nxt  = '0;
      rst_done_set = 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= S_RST;
      rst_cnt <= '0;
      dec_rst <= 1'b1;
      dec_en  <= 1'b0;
    end else begin
      state   <= state_nxt;
      rst_cnt <= rst_cnt_nxt;
      dec_rst <= (state_nxt == S_RST);
      dec_en  <= (state_nxt == S_RUN);
    end
  end

`ifdef MP3DEC_WDOG_EN
  localparam int WD_W = $clog2(WDOG_LIMIT + 1);
  logic [WD_W-1:0]  wdog_cnt;
  logic [CNT_W-1:0] ififo_q, ofifo_q;
  logic             stalled;

  assign stalled   = run && (ififo_cnt == ififo_q) && (ofifo_cnt == ofifo_q);
  assign wdog_fire = stalled && (wdog_cnt == WD_W'(WDOG_LIMIT - 1));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wdog_cnt <= '0;
      ififo_q  <= '0;
      ofifo_q  <= '0;
    end else begin
      ififo_q  <= ififo_cnt;
      ofifo_q  <= ofifo_cnt;
      if (!stalled || wdog_fire) wdog_cnt <= '0;
      else                       wdog_cnt <= wdog_cnt + 1'b1;
    end
  end
`else
  logic unused_wdog_cfg;
  assign wdog_fire       = 1'b0;
  assign unused_wdog_cfg = (WDOG_LIMIT > 0);
`endif

  // Level flags only latch on a rising edge seen while running
  assign int_set = {wdog_fire, rst_done_set,
                    run & out_high & ~out_high_q,
                    run & in_low & ~in_low_q};
  assign int_clr = (wr_stb && (reg_idx == 6'h03)) ? reg_wdata[3:0] : 4'h0;

  always_comb begin
    rd_mux = '0;
    case (reg_idx)
      6'h01: rd_mux[5:0] = {out_high, in_low, busy_sync, state};
      6'h02: rd_mux[3:0] = int_en;
      6'h03: rd_mux[3:0] = int_stat;
      6'h04: begin
        rd_mux[CNT_W-1:0]  = in_thr;
        rd_mux[16 +: CNT_W] = out_thr;
      end
      6'h05: begin
        rd_mux[CNT_W-1:0]  = ififo_cnt;
        rd_mux[16 +: CNT_W] = ofifo_cnt;
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      int_en     <= 4'h0;
      int_stat   <= 4'h0;
      in_thr     <= CNT_W'(256);
      out_thr    <= CNT_W'(768);
      in_low_q   <= 1'b0;
      out_high_q <= 1'b0;
      intr       <= 1'b0;
      reg_rdata  <= 32'h0;
    end else begin
      if (wr_stb && (reg_idx == 6'h02)) int_en <= reg_wdata[3:0] & INT_MASK;
      if (wr_stb && (reg_idx == 6'h04)) begin
        in_thr  <= reg_wdata[CNT_W-1:0];
        out_thr <= reg_wdata[16 +: CNT_W];
      end
      int_stat   <= ((int_stat & ~int_clr) | int_set) & INT_MASK;
      in_low_q   <= run & in_low;
      out_high_q <= run & out_high;
      intr       <= |(int_stat & int_en);
      if (rd_stb) reg_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_mp3dec_ctrl.sv
// Bench for mp3dec_ctrl: scenario tasks with randomized FIFO levels checked against a simple flag/event model.
module tb_mp3dec_ctrl;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        reg_sel = 1'b0;
  logic        reg_wr = 1'b0;
  logic [7:0]  reg_addr = 8'h0;
  logic [31:0] reg_wdata = 32'h0;
  logic [31:0] reg_rdata;
  logic [9:0]  ififo_cnt = 10'd0;
  logic [9:0]  ofifo_cnt = 10'd0;
  logic        fifo_rst_busy = 1'b1;
  logic        dec_rst, dec_en, intr;

  int n_pass = 0;
  int n_tot  = 0;

  int m_in_thr  = 256;
  int m_out_thr = 768;
`ifdef MP3DEC_WDOG_EN
  localparam logic [31:0] EN_MASK = 32'hF;
`else
  localparam logic [31:0] EN_MASK = 32'h7;
`endif

  mp3dec_ctrl dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .reg_sel(reg_sel), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .ififo_cnt(ififo_cnt), .ofifo_cnt(ofifo_cnt), .fifo_rst_busy(fifo_rst_busy),
    .dec_rst(dec_rst), .dec_en(dec_en), .intr(intr)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    reg_sel = 1'b1; reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_sel = 1'b0; reg_wr = 1'b0; reg_wdata = 32'h0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    reg_sel = 1'b1; reg_wr = 1'b0; reg_addr = a;
    tick();
    reg_sel = 1'b0;
    d = reg_rdata;
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] v;
    bit ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      rd(8'h04, v);
      if (v[2:0] == 3'd0) begin ok = 1'b1; break; end
    end
    n_tot++;
    if (!ok) $display("FAIL %s: state=%0d, required 0 (IDLE) within 12 cycles", name, v[2:0]);
    else n_pass++;
  endtask

  task automatic test_reset();
    logic [31:0] v, exp;
    int n;
    bit en_seen;
    repeat (3) tick();
    n_tot++; if (dec_rst !== 1'b1) $display("FAIL rst_dec_rst: got %b want 1", dec_rst); else n_pass++;
    n_tot++; if (dec_en !== 1'b0) $display("FAIL rst_dec_en: got %b want 0", dec_en); else n_pass++;
    n_tot++; if (intr !== 1'b0) $display("FAIL rst_intr: got %b want 0", intr); else n_pass++;
    n_tot++; if (reg_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", reg_rdata); else n_pass++;
    HRESETn = 1'b1;
    n = 0; en_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (dec_rst === 1'b1) n++;
      if (dec_en !== 1'b0) en_seen = 1'b1;
      tick();
    end
    n_tot++; if (n != 16) $display("FAIL rst_len: dec_rst high %0d cycles, want 16", n); else n_pass++;
    n_tot++; if (en_seen) $display("FAIL rst_en_low: dec_en rose during reset, want 0"); else n_pass++;
    rd(8'h04, v);
    exp = {26'd0, (int'(ofifo_cnt) >= m_out_thr), (int'(ififo_cnt) <= m_in_thr), 1'b1, 3'd2};
    n_tot++; if (v !== exp) $display("FAIL rst_status_wait: got %h want %h", v, exp); else n_pass++;
    fifo_rst_busy = 1'b0;
    wait_idle("rst_to_idle");
    rd(8'h0C, v);
    n_tot++; if (v !== 32'h4) $display("FAIL rst_int_stat: got %h want 4", v); else n_pass++;
    rd(8'h10, v);
    exp = (32'(m_out_thr) << 16) | 32'(m_in_thr);
    n_tot++; if (v !== exp) $display("FAIL rst_thresh: got %h want %h", v, exp); else n_pass++;
    rd(8'h08, v);
    n_tot++; if (v !== 32'h0) $display("FAIL rst_int_en: got %h want 0", v); else n_pass++;
  endtask

  task automatic test_in_low();
    logic [31:0] v;
    bit prev, flag, sticky;
    m_in_thr = $urandom_range(100, 900);
    wr(8'h10, (32'(m_out_thr) << 16) | 32'(m_in_thr));
    wr(8'h08, 32'h1);
    ififo_cnt = 10'(m_in_thr + $urandom_range(1, 50));
    ofifo_cnt = 10'd0;
    wr(8'h0C, 32'hF);
    wr(8'h00, 32'h1);
    n_tot++; if (dec_en !== 1'b1) $display("FAIL start_dec_en: got %b want 1", dec_en); else n_pass++;
    ififo_cnt = 10'(m_in_thr - $urandom_range(0, 50));
    tick();
    n_tot++; if (intr !== 1'b0) $display("FAIL in_low_intr_lag: got %b want 0", intr); else n_pass++;
    tick();
    n_tot++; if (intr !== 1'b1) $display("FAIL in_low_intr: got %b want 1", intr); else n_pass++;
    rd(8'h0C, v);
    n_tot++; if (v !== 32'h1) $display("FAIL in_low_stat: got %h want 1", v); else n_pass++;
    wr(8'h0C, 32'h1);
    tick();
    n_tot++; if (intr !== 1'b0) $display("FAIL in_low_w1c_intr: got %b want 0", intr); else n_pass++;
    // Random walk around the threshold: a flag latches only on 0->1 transitions
    prev = 1'b1; sticky = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) == 1) ififo_cnt = 10'(m_in_thr - $urandom_range(0, 40));
      else                           ififo_cnt = 10'(m_in_thr + $urandom_range(1, 40));
      tick();
      flag = (int'(ififo_cnt) <= m_in_thr);
      sticky = sticky | (flag & ~prev);
      prev = flag;
      rd(8'h0C, v);
      n_tot++; if (v !== {31'd0, sticky}) $display("FAIL in_low_walk[%0d]: got %h want %h (cnt %0d thr %0d)", i, v, {31'd0, sticky}, ififo_cnt, m_in_thr); else n_pass++;
      n_tot++; if (intr !== sticky) $display("FAIL in_low_walk_intr[%0d]: got %b want %b", i, intr, sticky); else n_pass++;
      if (sticky) begin
        wr(8'h0C, 32'h1);
        sticky = 1'b0;
      end
    end
  endtask

  task automatic test_out_high();
    logic [31:0] v;
    m_out_thr = $urandom_range(10, 1000);
    wr(8'h10, (32'(m_out_thr) << 16) | 32'(m_in_thr));
    ofifo_cnt = 10'(m_out_thr - 1);
    tick();
    rd(8'h0C, v);
    n_tot++; if (v[1] !== 1'b0) $display("FAIL out_high_below: got %b want 0", v[1]); else n_pass++;
    ofifo_cnt = 10'(m_out_thr);
    wr(8'h0C, 32'h2);
    rd(8'h0C, v);
    n_tot++; if (v[1] !== 1'b1) $display("FAIL out_high_set_wins: got %b want 1", v[1]); else n_pass++;
    wr(8'h0C, 32'h0);
    rd(8'h0C, v);
    n_tot++; if (v[1] !== 1'b1) $display("FAIL w1c_zero: got %b want 1", v[1]); else n_pass++;
    wr(8'h0C, 32'h2);
    rd(8'h0C, v);
    n_tot++; if (v[1] !== 1'b0) $display("FAIL out_high_w1c: got %b want 0", v[1]); else n_pass++;
  endtask

  task automatic test_srst();
    int n;
    bit all_high;
    wr(8'h00, 32'h7);
    n_tot++; if (dec_en !== 1'b0) $display("FAIL srst_dec_en: got %b want 0", dec_en); else n_pass++;
    n_tot++; if (dec_rst !== 1'b1) $display("FAIL srst_dec_rst: got %b want 1", dec_rst); else n_pass++;
    all_high = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (dec_rst !== 1'b1) all_high = 1'b0;
    end
    n_tot++; if (!all_high) $display("FAIL srst_hold: dec_rst dropped before cycle 10, want 1"); else n_pass++;
    wr(8'h00, 32'h4);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (dec_rst !== 1'b1) break;
      n++;
      tick();
    end
    n_tot++; if (n != 16) $display("FAIL srst_restart_len: dec_rst high %0d cycles, want 16", n); else n_pass++;
    wait_idle("srst_to_idle");
    n_tot++; if (dec_en !== 1'b0) $display("FAIL srst_no_start: dec_en got %b want 0", dec_en); else n_pass++;
  endtask

  task automatic test_ignored();
    logic [31:0] v, exp;
    logic [9:0] a, b;
    int n;
    fifo_rst_busy = 1'b1;
    wr(8'h00, 32'h4);
    n = 0;
    while (dec_rst === 1'b1 && n < 40) begin tick(); n++; end
    n_tot++; if (dec_rst !== 1'b0) $display("FAIL ign_reset_end: dec_rst got %b want 0", dec_rst); else n_pass++;
    wr(8'h00, 32'h1);
    rd(8'h04, v);
    n_tot++; if (v[2:0] !== 3'd2) $display("FAIL start_in_wait: state %0d want 2", v[2:0]); else n_pass++;
    n_tot++; if (dec_en !== 1'b0) $display("FAIL start_in_wait_en: got %b want 0", dec_en); else n_pass++;
    fifo_rst_busy = 1'b0;
    wait_idle("ign_to_idle");
    wr(8'h00, 32'h2);
    rd(8'h04, v);
    n_tot++; if (v[2:0] !== 3'd0) $display("FAIL stop_in_idle: state %0d want 0", v[2:0]); else n_pass++;
    rd(8'h40, v);
    n_tot++; if (v !== 32'h0) $display("FAIL unmapped_read: got %h want 0", v); else n_pass++;
    rd(8'h00, v);
    n_tot++; if (v !== 32'h0) $display("FAIL ctrl_read: got %h want 0", v); else n_pass++;
    wr(8'h40, $urandom());
    rd(8'h10, v);
    exp = (32'(m_out_thr) << 16) | 32'(m_in_thr);
    n_tot++; if (v !== exp) $display("FAIL unmapped_write: thresh %h want %h", v, exp); else n_pass++;
    wr(8'h08, 32'hF);
    rd(8'h08, v);
    n_tot++; if (v !== EN_MASK) $display("FAIL int_en_mask: got %h want %h", v, EN_MASK); else n_pass++;
    wr(8'h08, 32'h0);
    for (int i = 0; i < 4; i++) begin
      a = 10'($urandom_range(0, 1023));
      b = 10'($urandom_range(0, 1023));
      ififo_cnt = a; ofifo_cnt = b;
      rd(8'h14, v);
      exp = (32'(b) << 16) | 32'(a);
      n_tot++; if (v !== exp) $display("FAIL fifocnt[%0d]: got %h want %h", i, v, exp); else n_pass++;
    end
  endtask

  task automatic test_wdog();
    logic [31:0] v;
    int k;
    wr(8'h0C, 32'hF);
    wr(8'h00, 32'h1);
    k = 0;
    while (dec_rst !== 1'b1 && k < 5000) begin tick(); k++; end
    rd(8'h0C, v);
`ifdef MP3DEC_WDOG_EN
    n_tot++; if (k != 4096) $display("FAIL wdog_fire_cycle: fired after %0d stall cycles, want 4096", k); else n_pass++;
    n_tot++; if (v[3] !== 1'b1) $display("FAIL wdog_stat: got %b want 1", v[3]); else n_pass++;
`else
    n_tot++; if (k != 5000 || dec_en !== 1'b1) $display("FAIL wdog_absent: reset after %0d cycles, dec_en %b; want none, 1", k, dec_en); else n_pass++;
    n_tot++; if (v[3] !== 1'b0) $display("FAIL wdog_stat: got %b want 0", v[3]); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_in_low();
    test_out_high();
    test_srst();
    test_ignored();
    test_wdog();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit, required completion");
    $fatal(1);
  end

endmodule
